writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath and register-data width in bits; legal values 32 and 64.
REQ-002 Parameter RADDR_W, default 5, register-file address width.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  memory-stage instruction presented.
REQ-006 Port in_ready  output  1  unit accepts an instruction this cycle.
REQ-007 Port execute_out_in  input  XLEN  ALU/execute result.
REQ-008 Port pc_plus4_in  input  XLEN  link value for jumps.
REQ-009 Port csr_data_in  input  XLEN  CSR read value.
REQ-010 Port wb_sel_in  input  2  source select: 00 execute, 01 load, 10 pc+4, 11 CSR.
REQ-011 Port load_size_in  input  2  00 byte, 01 half, 10 word, 11 doubleword (XLEN=64 only).
REQ-012 Port load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend.
REQ-013 Port load_offset_in  input  3  low address bits of the load.
REQ-014 Port reg_write_addr_in  input  RADDR_W  destination register.
REQ-015 Port reg_write_en_in  input  1  instruction writes a register.
REQ-016 Port dmem_rvalid  input  1  load response valid.
REQ-017 Port dmem_rdata  input  XLEN  load response data, naturally aligned word/doubleword.
REQ-018 Port flush  input  1  discard the instruction in flight.
REQ-019 Port reg_writedata_out  output  XLEN  registered write data.
REQ-020 Port reg_write_addr_out  output  RADDR_W  registered write address.
REQ-021 Port reg_write_en_out  output  1  registered one-cycle write strobe.
REQ-022 Port wb_busy  output  1  high in any state other than IDLE.
REQ-023 Port retire_count  output  32  count of committed register writes.

Function
REQ-024 The FSM SHALL have exactly three states: IDLE, WAIT_MEM and DRAIN.
REQ-025 in_ready SHALL be 1 in IDLE only; an instruction is accepted on in_valid && in_ready && !flush.
REQ-026 An accepted instruction with wb_sel_in != 01 SHALL assert reg_write_en_out in the following cycle (latency 1), and the state SHALL remain IDLE.
REQ-027 An accepted instruction with wb_sel_in = 01 SHALL latch size, unsigned, offset, address and enable, and SHALL move to WAIT_MEM.
REQ-028 In WAIT_MEM, dmem_rvalid && !flush SHALL register the extracted load data, pulse reg_write_en_out in the next cycle, and return to IDLE.
REQ-029 Load extraction SHALL work as follows.
- Byte: dmem_rdata[8*off +: 8].
- Half: the halfword selected by off[2:1] (off[0] ignored).
- Word: the word selected by off[2] (XLEN=64); offset ignored at XLEN=32.
- Doubleword: the full data.
- Extension: zero or sign to XLEN per load_unsigned_in.
REQ-030 load_size_in = 11 at XLEN=32 SHALL be treated as word.
REQ-031 reg_write_en_out SHALL be 0 whenever the latched enable is 0 or the destination address is 0; the data and address outputs still update.
REQ-032 reg_write_en_out SHALL be high for exactly one cycle per committed instruction.
REQ-033 flush in IDLE SHALL block acceptance; no write results.
REQ-034 flush in WAIT_MEM without dmem_rvalid SHALL move to DRAIN, with no write.
REQ-035 flush in WAIT_MEM in the same cycle as dmem_rvalid SHALL discard the response and return to IDLE.
REQ-036 In DRAIN, dmem_rvalid SHALL be discarded and the state SHALL return to IDLE; flush SHALL have no further effect in DRAIN.
REQ-037 dmem_rvalid in IDLE SHALL be ignored.
REQ-038 retire_count SHALL increment by 1 on every cycle with reg_write_en_out = 1, and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-039 Reset SHALL force state to IDLE and clear all outputs to 0: reg_writedata_out, reg_write_addr_out, reg_write_en_out, wb_busy and retire_count.
REQ-040 Reset SHALL take priority over every other input, including mid-load; a response arriving after reset SHALL be ignored.

Verification
REQ-041 Scenario: ALU path, execute_out_in = 0x0000_1234, addr 5, sel 00 -> next cycle writedata 0x1234, addr 5, en 1 for one cycle; retire_count = 1.
REQ-042 Scenario: signed byte load, offset 3, dmem_rdata = 0x80AA_BBCC, rvalid two cycles after accept -> writedata 0xFFFF_FF80, in_ready 0 while waiting.
REQ-043 Scenario: unsigned half load, offset 2, data 0xF00D_1234 -> writedata 0x0000_F00D; a signed half load of the same data -> 0xFFFF_F00D.
REQ-044 Scenario: destination x0 with sel 10, pc+4 = 0x100 -> en stays 0 and retire_count is unchanged.
REQ-045 Scenario: load accepted, flush the next cycle, rvalid two cycles later -> state goes to DRAIN then IDLE, no write, and a new instruction is accepted the cycle after.
REQ-046 Scenario: reset asserted in WAIT_MEM, rvalid the next cycle -> no write, all outputs 0, in_ready 1.

Source files
------------

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - pipeline writeback stage: result select, load extraction, register-write strobe
module writeback_unit #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    execute_out_in,
    input  logic [XLEN-1:0]    pc_plus4_in,
    input  logic [XLEN-1:0]    csr_data_in,
    input  logic [1:0]         wb_sel_in,
    input  logic [1:0]         load_size_in,
    input  logic               load_unsigned_in,
    input  logic [2:0]         load_offset_in,
    input  logic [RADDR_W-1:0] reg_write_addr_in,
    input  logic               reg_write_en_in,
    input  logic               dmem_rvalid,
    input  logic [XLEN-1:0]    dmem_rdata,
    input  logic               flush,
    output logic [XLEN-1:0]    reg_writedata_out,
    output logic [RADDR_W-1:0] reg_write_addr_out,
    output logic               reg_write_en_out,
    output logic               wb_busy,
    output logic [31:0]        retire_count
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_t;

    state_t               state, state_next;
    logic [1:0]           ld_size;
    logic                 ld_unsigned;
    logic [2:0]           ld_offset;
    logic [RADDR_W-1:0]   ld_addr;
    logic                 ld_en;

    logic                 accept, is_load, alu_commit, load_commit, load_accept;
    logic [XLEN-1:0]      alu_data, load_data, shifted, mask, fill;
    logic [1:0]           size_eff;
    logic [2:0]           off_eff;
    logic [5:0]           shamt;
    logic                 sbit;

    assign in_ready    = (state == IDLE);
    assign wb_busy     = (state != IDLE);
    assign is_load     = (wb_sel_in == 2'b01);
    assign accept      = in_valid && in_ready && !flush;
    assign alu_commit  = accept && !is_load;
    assign load_accept = accept && is_load;
    assign load_commit = (state == WAIT_MEM) && dmem_rvalid && !flush;

    always_comb begin
        alu_data = execute_out_in;
        case (wb_sel_in)
            2'b10:   alu_data = pc_plus4_in;
            2'b11:   alu_data = csr_data_in;
            default: alu_data = execute_out_in;
        endcase
    end

    // Shift the addressed lane down to bit 0, then mask and extend by size.
    always_comb begin
        size_eff = ld_size;
        off_eff  = ld_offset;
        if (XLEN == 32) begin
            off_eff[2] = 1'b0;
            if (ld_size == 2'b11) size_eff = 2'b10;
        end
        case (size_eff)
            2'b00:   begin shamt = {off_eff, 3'b000};         mask = XLEN'(64'hFF);        end
            2'b01:   begin shamt = {off_eff[2:1], 4'b0000};   mask = XLEN'(64'hFFFF);      end
            2'b10:   begin shamt = {off_eff[2], 5'b00000};    mask = XLEN'(64'hFFFF_FFFF); end
            default: begin shamt = 6'd0;                      mask = '1;                   end
        endcase
        shifted = dmem_rdata >> shamt;
        case (size_eff)
            2'b00:   sbit = shifted[7];
            2'b01:   sbit = shifted[15];
            2'b10:   sbit = shifted[31];
            default: sbit = shifted[XLEN-1];
        endcase
        fill      = (!ld_unsigned && sbit) ? '1 : '0;
        load_data = (shifted & mask) | (fill & ~mask);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (load_accept) state_next = WAIT_MEM;
            WAIT_MEM: begin
                if (flush)            state_next = dmem_rvalid ? IDLE : DRAIN;
                else if (dmem_rvalid) state_next = IDLE;
            end
            DRAIN:    if (dmem_rvalid) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            ld_size            <= '0;
            ld_unsigned        <= 1'b0;
            ld_offset          <= '0;
            ld_addr            <= '0;
            ld_en              <= 1'b0;
            reg_writedata_out  <= '0;
            reg_write_addr_out <= '0;
            reg_write_en_out   <= 1'b0;
            retire_count       <= '0;
        end else begin
            state            <= state_next;
            reg_write_en_out <= 1'b0;
            retire_count     <= retire_count + 32'(reg_write_en_out);
            if (alu_commit) begin
                reg_writedata_out  <= alu_data;
                reg_write_addr_out <= reg_write_addr_in;
                reg_write_en_out   <= reg_write_en_in && (reg_write_addr_in != '0);
            end
            if (load_accept) begin
                ld_size     <= load_size_in;
                ld_unsigned <= load_unsigned_in;
                ld_offset   <= load_offset_in;
                ld_addr     <= reg_write_addr_in;
                ld_en       <= reg_write_en_in;
            end
            if (load_commit) begin
                reg_writedata_out  <= load_data;
                reg_write_addr_out <= ld_addr;
                reg_write_en_out   <= ld_en && (ld_addr != '0);
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] execute_out_in, pc_plus4_in, csr_data_in;
    logic [1:0]  wb_sel_in, load_size_in;
    logic        load_unsigned_in;
    logic [2:0]  load_offset_in;
    logic [4:0]  reg_write_addr_in;
    logic        reg_write_en_in;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        flush;
    logic [31:0] reg_writedata_out;
    logic [4:0]  reg_write_addr_out;
    logic        reg_write_en_out;
    logic        wb_busy;
    logic [31:0] retire_count;

    int errors = 0;
    int checks = 0;

    writeback_unit #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .execute_out_in(execute_out_in), .pc_plus4_in(pc_plus4_in), .csr_data_in(csr_data_in),
        .wb_sel_in(wb_sel_in), .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
        .load_offset_in(load_offset_in), .reg_write_addr_in(reg_write_addr_in),
        .reg_write_en_in(reg_write_en_in), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .flush(flush), .reg_writedata_out(reg_writedata_out), .reg_write_addr_out(reg_write_addr_out),
        .reg_write_en_out(reg_write_en_out), .wb_busy(wb_busy), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] addr, input logic en,
                         input logic [1:0] size, input logic uns, input logic [2:0] off);
        in_valid          = 1'b1;
        wb_sel_in         = sel;
        reg_write_addr_in = addr;
        reg_write_en_in   = en;
        load_size_in      = size;
        load_unsigned_in  = uns;
        load_offset_in    = off;
        step();
        in_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        dmem_rvalid = 1'b1;
        dmem_rdata  = data;
        step();
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; execute_out_in = '0; pc_plus4_in = '0; csr_data_in = '0;
        wb_sel_in = '0; load_size_in = '0; load_unsigned_in = 1'b0; load_offset_in = '0;
        reg_write_addr_in = '0; reg_write_en_in = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        flush = 1'b0;
        step(); step();
        check("rst_wd", reg_writedata_out, 0);
        check("rst_en", reg_write_en_out, 0);
        check("rst_busy", wb_busy, 0);
        check("rst_cnt", retire_count, 0);
        reset = 1'b0;
        step();
        check("rst_ready", in_ready, 1);

        // ALU result
        execute_out_in = 32'h0000_1234;
        issue(2'b00, 5'd5, 1'b1, 2'b00, 1'b0, 3'd0);
        check("alu_wd", reg_writedata_out, 32'h1234);
        check("alu_addr", reg_write_addr_out, 5);
        check("alu_en", reg_write_en_out, 1);
        step();
        check("alu_en_pulse", reg_write_en_out, 0);
        check("alu_cnt", retire_count, 1);

        // signed byte load, offset 3
        issue(2'b01, 5'd6, 1'b1, 2'b00, 1'b0, 3'd3);
        check("lb_ready_wait", in_ready, 0);
        check("lb_busy", wb_busy, 1);
        check("lb_no_early_en", reg_write_en_out, 0);
        step();
        check("lb_ready_wait2", in_ready, 0);
        respond(32'h80AA_BBCC);
        check("lb_wd", reg_writedata_out, 32'hFFFF_FF80);
        check("lb_addr", reg_write_addr_out, 6);
        check("lb_en", reg_write_en_out, 1);
        check("lb_ready_back", in_ready, 1);
        step();
        check("lb_cnt", retire_count, 2);

        // half loads at offset 2, unsigned then signed
        issue(2'b01, 5'd7, 1'b1, 2'b01, 1'b1, 3'd2);
        respond(32'hF00D_1234);
        check("lhu_wd", reg_writedata_out, 32'h0000_F00D);
        check("lhu_en", reg_write_en_out, 1);
        issue(2'b01, 5'd7, 1'b1, 2'b01, 1'b0, 3'd3);
        respond(32'hF00D_1234);
        check("lh_wd", reg_writedata_out, 32'hFFFF_F00D);

        // byte offset 1 unsigned, then size 11 treated as word at XLEN=32
        issue(2'b01, 5'd8, 1'b1, 2'b00, 1'b1, 3'd1);
        respond(32'h1122_F344);
        check("lbu_wd", reg_writedata_out, 32'h0000_00F3);
        issue(2'b01, 5'd9, 1'b1, 2'b11, 1'b0, 3'd0);
        respond(32'h8765_4321);
        check("ld_as_word", reg_writedata_out, 32'h8765_4321);
        step();
        check("loads_cnt", retire_count, 6);

        // destination x0 via pc+4: data updates, no strobe
        pc_plus4_in = 32'h100;
        issue(2'b10, 5'd0, 1'b1, 2'b00, 1'b0, 3'd0);
        check("x0_wd", reg_writedata_out, 32'h100);
        check("x0_en", reg_write_en_out, 0);
        step();
        check("x0_cnt", retire_count, 6);

        // CSR source with write enable clear
        csr_data_in = 32'hCAFE_0001;
        issue(2'b11, 5'd10, 1'b0, 2'b00, 1'b0, 3'd0);
        check("csr_wd", reg_writedata_out, 32'hCAFE_0001);
        check("csr_noen", reg_write_en_out, 0);

        // flush in IDLE blocks acceptance; rvalid in IDLE ignored
        execute_out_in = 32'hDEAD_0000;
        flush = 1'b1;
        issue(2'b00, 5'd11, 1'b1, 2'b00, 1'b0, 3'd0);
        flush = 1'b0;
        check("flush_idle_en", reg_write_en_out, 0);
        check("flush_idle_wd", reg_writedata_out, 32'hCAFE_0001);
        respond(32'h1);
        check("rvalid_idle_en", reg_write_en_out, 0);
        check("rvalid_idle_ready", in_ready, 1);

        // flush while waiting -> DRAIN, response discarded, then IDLE
        issue(2'b01, 5'd12, 1'b1, 2'b10, 1'b0, 3'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("drain_busy", wb_busy, 1);
        check("drain_ready", in_ready, 0);
        check("drain_no_en", reg_write_en_out, 0);
        respond(32'h5555_5555);
        check("drain_done_en", reg_write_en_out, 0);
        check("drain_done_ready", in_ready, 1);
        execute_out_in = 32'h0000_00AB;
        issue(2'b00, 5'd13, 1'b1, 2'b00, 1'b0, 3'd0);
        check("after_drain_en", reg_write_en_out, 1);
        check("after_drain_wd", reg_writedata_out, 32'hAB);

        // flush together with rvalid discards the response
        issue(2'b01, 5'd14, 1'b1, 2'b10, 1'b0, 3'd0);
        flush = 1'b1;
        respond(32'h7777_7777);
        flush = 1'b0;
        check("flush_rv_en", reg_write_en_out, 0);
        check("flush_rv_ready", in_ready, 1);
        check("flush_rv_cnt", retire_count, 7);

        // reset mid-load; late response ignored
        issue(2'b01, 5'd15, 1'b1, 2'b10, 1'b0, 3'd0);
        check("pre_rst_busy", wb_busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        respond(32'h9999_9999);
        check("mid_rst_en", reg_write_en_out, 0);
        check("mid_rst_wd", reg_writedata_out, 0);
        check("mid_rst_addr", reg_write_addr_out, 0);
        check("mid_rst_cnt", retire_count, 0);
        check("mid_rst_busy", wb_busy, 0);
        check("mid_rst_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
